// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM encoding and
// the default transmit pattern.
package serial_pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } tx_state_t;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/serial_pattern_tx_pattern_shifter.sv
// Pattern register plus bit-index counter; presents the MSB and the next
// lower bit so the top can register whichever one it is about to drive.
import serial_pattern_tx_pkg::*;

module pattern_shifter #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             restart,
    input  logic             advance,
    output logic             msb,
    output logic             nxt_bit,
    output logic             at_lsb
);

    localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IW-1:0] IDX_MSB = IW'(PAT_W - 1);

    logic [PAT_W-1:0] pat;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_m1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat <= PATTERN;
            idx <= IDX_MSB;
        end else begin
            if (load)
                pat <= pat_in;
            if (restart)
                idx <= IDX_MSB;
            else if (advance)
                idx <= idx_m1;
        end
    end

    assign idx_m1  = idx - 1'b1;
    // A load on the start edge must be visible immediately as the first bit.
    assign msb     = load ? pat_in[PAT_W-1] : pat[PAT_W-1];
    assign nxt_bit = (idx == '0) ? pat[0] : pat[idx_m1];
    assign at_lsb  = (idx == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends the pattern MSB-first for rep passes,
// optionally separated by a one-cycle gap, with start/busy/done and abort.
import serial_pattern_tx_pkg::*;

module serial_pattern_tx #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int               CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] rep,
    input  logic             gap_en,
    output logic             dout,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    tx_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             gap_q, gap_nxt;
    logic             dout_d, valid_d, busy_d, done_d;
    logic             sh_load, sh_restart, sh_advance;
    logic             msb, nxt_bit, at_lsb;
    logic             go, last_pass;

    pattern_shifter #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .load    (sh_load),
        .pat_in  (pat_in),
        .restart (sh_restart),
        .advance (sh_advance),
        .msb     (msb),
        .nxt_bit (nxt_bit),
        .at_lsb  (at_lsb)
    );

    assign go        = start && !abort && (rep != '0);
    assign last_pass = (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            gap_q <= 1'b0;
            dout  <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            gap_q <= gap_nxt;
            dout  <= dout_d;
            valid <= valid_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (go) state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (abort)
                    state_nxt = ST_IDLE;
                else if (at_lsb)
                    state_nxt = last_pass ? ST_IDLE : (gap_q ? ST_GAP : ST_SHIFT);
            end
            ST_GAP:   state_nxt = abort ? ST_IDLE : ST_SHIFT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Computes the values the output registers take at the coming edge.
    always_comb begin
        dout_d     = 1'b0;
        valid_d    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        sh_load    = 1'b0;
        sh_restart = 1'b0;
        sh_advance = 1'b0;
        cnt_nxt    = cnt;
        gap_nxt    = gap_q;
        case (state)
            ST_IDLE: begin
                sh_load = load;
                if (go) begin
                    cnt_nxt    = rep;
                    gap_nxt    = gap_en;
                    sh_restart = 1'b1;
                    dout_d     = msb;
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    sh_restart = 1'b1;
                end else if (at_lsb) begin
                    cnt_nxt    = cnt - 1'b1;
                    sh_restart = 1'b1;
                    if (last_pass) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                        if (!gap_q) begin
                            dout_d  = msb;
                            valid_d = 1'b1;
                        end
                    end
                end else begin
                    sh_advance = 1'b1;
                    dout_d     = nxt_bit;
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    sh_restart = 1'b1;
                end else begin
                    dout_d  = msb;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            default: sh_restart = 1'b1;
        endcase
    end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial pattern transmitter: holds a PAT_W-bit pattern (default 1011) and drives it MSB-first, one bit per clock, onto a single-bit serial line for a programmable number of passes, with an optional one-cycle idle gap between passes. It is the stimulus/transmit end for the team's serial sequence detectors and sits directly on their `din` input. A start/busy/done handshake is provided, plus a synchronous abort.

## Interface
- `PAT_W`, 4: pattern width in bits (≥2).
- `PATTERN`, 4'b1011: reset value of the pattern register.
- `CNT_W`, 4: width of the pass count.
- `clk`  in  1: single clock, all logic on posedge.
- `reset`  in  1: asynchronous, active-low; forces the reset state immediately.
- `start`  in  1: begin a run; sampled on posedge, honoured only in IDLE.
- `abort`  in  1: synchronous; terminates the current run.
- `load`  in  1: load `pat_in` into the pattern register; honoured only in IDLE.
- `pat_in`  in  PAT_W: new pattern.
- `rep`  in  CNT_W: number of passes, latched at start.
- `gap_en`  in  1: insert one idle cycle between passes; latched at start.
- `dout`  out  1: serial data.
- `valid`  out  1: `dout` carries a pattern bit.
- `busy`  out  1: run in progress.
- `done`  out  1: one-cycle pulse on normal completion.

## Operation
- All outputs are registered. Reset values: `dout`=0, `valid`=0, `busy`=0, `done`=0. Internally: pattern register = `PATTERN`, state = IDLE, bit index = PAT_W-1, pass counter = 0.
- States: IDLE, SHIFT, GAP.
- **IDLE**
  - `load`=1: the pattern register takes `pat_in`.
  - `start`=1 with `rep`≠0: latch `rep` and `gap_en`, go to SHIFT. At that same edge, drive `dout`=MSB of the active pattern and set `valid`=1, `busy`=1.
  - `load` and `start` on the same edge: the run uses `pat_in`.
  - `start` with `rep`=0: ignored. No `busy`, no `done`.
- **SHIFT**
  - Each edge advances the bit index PAT_W-1 → 0 and drives `dout`=pattern[index], `valid`=1.
  - After bit 0 with passes remaining:
    - `gap_en`=1: go to GAP.
    - `gap_en`=0: restart at MSB on the next edge, giving a back-to-back stream.
  - After bit 0 of the final pass: go to IDLE. At that edge, `valid`=0, `dout`=0, `busy`=0, `done`=1 for exactly one cycle.
- **GAP**: one cycle with `dout`=0 and `valid`=0. Then SHIFT at MSB.
- `start` and `load` are ignored while `busy`=1. The pattern is stable for the whole run.
- `abort`=1 in SHIFT or GAP: next edge goes to IDLE with `dout`=0, `valid`=0, `busy`=0, and `done` stays 0. `abort` in IDLE has no effect. `abort` has priority over `start` on the same edge.
- Reset asserted mid-run: outputs drop to reset values asynchronously and the pattern register returns to `PATTERN`. No `done` is produced.
- Pass counter: CNT_W-bit down-counter, decremented after bit 0 of each pass. The run ends when it reaches 0, so there is no wrap-around. `rep`=2^CNT_W-1 is legal.

## Timing
- Latency: the first bit is on `dout` in the cycle after the edge that samples `start`.
- Run length in cycles: `rep`·PAT_W + (`rep`-1)·`gap_en`.
- `busy` is high for exactly the run length.
- `done` rises on the edge at which `busy` falls.
- A new `start` can be accepted on the edge after `done` (the cycle in which `done`=1 is IDLE).

## Structure
- Shared package holds the state encoding: IDLE=2'b00, SHIFT=2'b01, GAP=2'b10; 2'b11 is illegal and recovers to IDLE.
- The package also holds the default pattern constant 4'b1011.
- One natural sub-module, `pattern_shifter`: pattern register, bit-index counter and MSB-first bit select, with `load`/`restart`/`advance` controls.
- The FSM, pass counter and handshake stay in the top module.

## Test plan
- Reset, then `start` with `rep`=1, `gap_en`=0, default pattern → `dout` 1,0,1,1 over 4 cycles with `valid`=1; `busy` high 4 cycles; `done` pulses once.
- `rep`=2, `gap_en`=1 → `dout`/`valid` = 1/1,0/1,1/1,1/1,0/0,1/1,0/1,1/1,1/1; `busy` high 9 cycles.
- `load` 4'b0110 together with `start`, `rep`=1 → `dout` 0,1,1,0. A further `load` of 4'b1111 mid-run is ignored.
- `rep`=3, `gap_en`=0; assert `abort` on the 5th bit → `valid` and `busy` low on the next edge; `done` never pulses; a following `start` works normally.
- `start` with `rep`=0 → no activity. `start` pulsed while `busy` → ignored, and run length is unchanged.
- Assert reset during the 2nd pass → all outputs 0 immediately; the pattern returns to 4'b1011; a subsequent run is correct.
